// File: rtl/sales_pkg.sv
// sales_pkg: shared order record, default sizes and feeder FSM states
package sales_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int MAX_BATCH_DEF = 16;
  typedef struct packed {
    logic [31:0] price;
    logic [31:0] num;
  } order_t;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/order_fifo.sv
// order_fifo: power-of-two order queue with synchronous clear and same-edge push/pop
module order_fifo
  import sales_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  order_t wdata,
  output order_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  order_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointers wrap naturally because DEPTH is a power of two; clear beats push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/order_feeder.sv
// order_feeder: queues orders and issues them downstream in MAX_BATCH chunks (stats counters under ORDER_FEEDER_STATS_EN)
module order_feeder
  import sales_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int MAX_BATCH = MAX_BATCH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_price,
  input  logic [31:0] in_num,
  output logic [31:0] out_price,
  output logic [31:0] out_num,
  output logic        busy,
  output logic [15:0] order_cnt,
  output logic [15:0] drop_cnt
);
  localparam logic [31:0] MB = 32'(MAX_BATCH);
  state_t state, state_n;
  logic [31:0] cur_price, price_n, rem_num, rem_n, chunk;
  logic full, empty, fire, push, pop;
  order_t head;
  assign in_ready = !full && !flush;
  assign fire = in_valid && in_ready;
  assign push = fire && in_num != '0;
  assign chunk = state == ISSUE ? (rem_num < MB ? rem_num : MB) : '0;
  assign out_price = state == ISSUE ? cur_price : '0;
  assign out_num = chunk;
  assign busy = state == ISSUE || !empty;
  order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(flush),
    .push(push),
    .pop(pop),
    .wdata('{price: in_price, num: in_num}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // working registers for the order being issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_price <= '0;
      rem_num <= '0;
    end else begin
      state <= state_n;
      cur_price <= price_n;
      rem_num <= rem_n;
    end
  end
  // load the next head as soon as the current order finishes so back-to-back orders leave no gap
  always_comb begin
    state_n = state;
    price_n = cur_price;
    rem_n = rem_num;
    pop = 1'b0;
    if (flush) begin
      state_n = IDLE;
      rem_n = '0;
    end else if (state == IDLE || rem_num == chunk) begin
      if (!empty) begin
        pop = 1'b1;
        state_n = ISSUE;
        price_n = head.price;
        rem_n = head.num;
      end else begin
        state_n = IDLE;
        rem_n = '0;
      end
    end else begin
      rem_n = rem_num - chunk;
    end
  end
`ifdef ORDER_FEEDER_STATS_EN
  logic [15:0] order_q, drop_q;
  // saturating counts of stored and zero-quantity orders
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= '0;
      drop_q <= '0;
    end else begin
      if (push && order_q != 16'hFFFF) order_q <= order_q + 16'd1;
      if (fire && in_num == '0 && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
  assign order_cnt = order_q;
  assign drop_cnt = drop_q;
`else
  assign order_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule
